tmds_channel_encoder: RTL and testbench



---
 rtl/tmds_pkg.sv | 33 +++
 rtl/tmds_qm_stage.sv | 52 +++++
 rtl/tmds_channel_encoder.sv | 90 +++++++++
 tb/tb_tmds_channel_encoder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared types, code tables and helpers for the TMDS channel encoder.
// Every code is written with its MSB on the left; dout[0] is sent first.
package tmds_pkg;

  typedef enum logic [1:0] {
    CTRL  = 2'd0,
    VIDEO = 2'd1,
    TERC4 = 2'd2,
    GUARD = 2'd3
  } tmds_mode_t;

  localparam logic [9:0] CTRL_CODE [4] = '{
    10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
  };

  localparam logic [9:0] TERC4_CODE [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  localparam logic [9:0] GB_VID_CH02 = 10'b1011001100;
  localparam logic [9:0] GB_VID_CH1  = 10'b0100110011;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/tmds_qm_stage.sv
// Stage 1: XOR/XNOR transition minimiser plus the registered side-band
// (mode, ctrl, aux) that travels alongside it to stage 2.
module tmds_qm_stage
  import tmds_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  tmds_mode_t mode,
  input  logic [7:0] din,
  input  logic [1:0] ctrl,
  input  logic [3:0] aux,
  output logic [8:0] qm,
  output logic [3:0] n1q,
  output tmds_mode_t mode_q,
  output logic [1:0] ctrl_q,
  output logic [3:0] aux_q
);

  logic [3:0] n1d;
  logic       use_xnor;
  logic [8:0] qm_d;

  assign n1d      = popcount8(din);
  assign use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !din[0]);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    qm_d    = '0;
    qm_d[0] = din[0];
    for (int i = 1; i < 8; i++)
      qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ din[i]) : (qm_d[i-1] ^ din[i]);
    qm_d[8] = ~use_xnor;
  end

  // NOTE: registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      qm     <= '0;
      n1q    <= '0;
      mode_q <= CTRL;
      ctrl_q <= 2'b00;
      aux_q  <= '0;
    end else begin
      qm     <= qm_d;
      n1q    <= popcount8(qm_d[7:0]);
      mode_q <= mode;
      ctrl_q <= ctrl;
      aux_q  <= aux;
    end
  end

endmodule

// File: rtl/tmds_channel_encoder.sv
// Single-lane TMDS encoder: video 8b/10b with DC balance, CTRL, TERC4 and
// guard-band symbols, all with the same two-register latency.
module tmds_channel_encoder
  import tmds_pkg::*;
#(
  parameter int CHANNEL = 0,
  parameter int DISP_W  = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  tmds_mode_t               mode,
  input  logic [7:0]               din,
  input  logic [1:0]               ctrl,
  input  logic [3:0]               aux,
  output logic [9:0]               dout,
  output logic signed [DISP_W-1:0] disparity
);

  localparam logic [9:0]               GB_CODE = (CHANNEL == 1) ? GB_VID_CH1 : GB_VID_CH02;
  localparam logic signed [DISP_W-1:0] D_ZERO  = '0;
  localparam logic signed [DISP_W-1:0] D_TWO   = DISP_W'(2);
  localparam logic signed [DISP_W-1:0] D_EIGHT = DISP_W'(8);

  logic [8:0]               qm;
  logic [3:0]               n1q;
  tmds_mode_t               mode_q;
  logic [1:0]               ctrl_q;
  logic [3:0]               aux_q;

  logic [9:0]               dout_d;
  logic signed [DISP_W-1:0] cnt_q, cnt_d;
  logic signed [DISP_W-1:0] n1s, n0s, diff;
  logic                     cnt_pos, cnt_neg;

  tmds_qm_stage u_qm (
    .clk    (clk),
    .rst    (rst),
    .mode   (mode),
    .din    (din),
    .ctrl   (ctrl),
    .aux    (aux),
    .qm     (qm),
    .n1q    (n1q),
    .mode_q (mode_q),
    .ctrl_q (ctrl_q),
    .aux_q  (aux_q)
  );

  assign n1s     = $signed({{(DISP_W-4){1'b0}}, n1q});
  assign n0s     = D_EIGHT - n1s;
  assign diff    = n1s - n0s;
  assign cnt_neg = cnt_q[DISP_W-1];
  assign cnt_pos = !cnt_q[DISP_W-1] && (cnt_q != D_ZERO);

  always_comb begin
    dout_d = CTRL_CODE[0];
    cnt_d  = D_ZERO;
    unique case (mode_q)
      CTRL:  dout_d = CTRL_CODE[ctrl_q];
      TERC4: dout_d = TERC4_CODE[aux_q];
      GUARD: dout_d = GB_CODE;
      VIDEO: begin
        if ((cnt_q == D_ZERO) || (n1q == 4'd4)) begin
          dout_d = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
          cnt_d  = cnt_q + (qm[8] ? diff : -diff);
        end else if ((cnt_pos && (n1q > 4'd4)) || (cnt_neg && (n1q < 4'd4))) begin
          // Inverting the data pulls the running disparity back toward zero.
          dout_d = {1'b1, qm[8], ~qm[7:0]};
          cnt_d  = cnt_q + (qm[8] ? D_TWO : D_ZERO) - diff;
        end else begin
          dout_d = {1'b0, qm[8], qm[7:0]};
          cnt_d  = cnt_q + diff - (qm[8] ? D_ZERO : D_TWO);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout  <= CTRL_CODE[0];
      cnt_q <= D_ZERO;
    end else begin
      dout  <= dout_d;
      cnt_q <= cnt_d;
    end
  end

  assign disparity = cnt_q;

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Directed bench for tmds_channel_encoder: a symbol-level model checked every
// cycle on lanes 0 and 1, plus hand-computed literal expectations.
module tb_tmds_channel_encoder;
  import tmds_pkg::*;

  localparam int DISP_W = 5;

  logic                     clk, rst;
  tmds_mode_t               mode;
  logic [7:0]               din;
  logic [1:0]               ctrl;
  logic [3:0]               aux;
  logic [9:0]               dout0, dout1;
  logic signed [DISP_W-1:0] disp0, disp1;

  int vectors     = 0;
  int miscompares = 0;

  tmds_channel_encoder #(.CHANNEL(0), .DISP_W(DISP_W)) dut0 (
    .clk(clk), .rst(rst), .mode(mode), .din(din), .ctrl(ctrl), .aux(aux),
    .dout(dout0), .disparity(disp0)
  );

  tmds_channel_encoder #(.CHANNEL(1), .DISP_W(DISP_W)) dut1 (
    .clk(clk), .rst(rst), .mode(mode), .din(din), .ctrl(ctrl), .aux(aux),
    .dout(dout1), .disparity(disp1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (symbol level) ----------------
  localparam logic [9:0] M_CTRL [4] = '{
    10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
  };
  localparam logic [9:0] M_TERC4 [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  typedef struct { logic [9:0] sym; int cnt; } enc_t;
  typedef struct packed { tmds_mode_t m; logic [7:0] d; logic [1:0] c; logic [3:0] a; } sym_in_t;

  function automatic enc_t encode(input sym_in_t s, input int cnt_in, input int ch);
    enc_t       r;
    logic [8:0] q;
    bit         xn;
    int         n1, n0;
    r.cnt = 0;
    r.sym = 10'b1101010100;
    case (s.m)
      CTRL:  r.sym = M_CTRL[s.c];
      TERC4: r.sym = M_TERC4[s.a];
      GUARD: r.sym = (ch == 1) ? 10'b0100110011 : 10'b1011001100;
      default: begin
        xn   = ($countones(s.d) > 4) || ($countones(s.d) == 4 && s.d[0] == 1'b0);
        q[0] = s.d[0];
        for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ s.d[i]) : (q[i-1] ^ s.d[i]);
        q[8] = !xn;
        n1   = $countones(q[7:0]);
        n0   = 8 - n1;
        if (cnt_in == 0 || n1 == n0)
          r.sym = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
        else if ((cnt_in > 0 && n1 > n0) || (cnt_in < 0 && n0 > n1))
          r.sym = {1'b1, q[8], ~q[7:0]};
        else
          r.sym = {1'b0, q[8], q[7:0]};
        // Running disparity moves by (ones - zeros) of the emitted symbol.
        r.cnt = cnt_in + 2 * $countones(r.sym) - 10;
      end
    endcase
    return r;
  endfunction

  sym_in_t m_st1;
  enc_t    exp0, exp1;
  bit      model_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_st1 <= '{m: CTRL, d: 8'h00, c: 2'b00, a: 4'h0};
      exp0  <= '{sym: 10'b1101010100, cnt: 0};
      exp1  <= '{sym: 10'b1101010100, cnt: 0};
    end else begin
      exp0  <= encode(m_st1, exp0.cnt, 0);
      exp1  <= encode(m_st1, exp1.cnt, 1);
      m_st1 <= '{m: mode, d: din, c: ctrl, a: aux};
    end
    model_valid <= 1'b1;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("model_dout_ch0", dout0, exp0.sym);
      check("model_disp_ch0", disp0, exp0.cnt);
      check("model_dout_ch1", dout1, exp1.sym);
      check("model_disp_ch1", disp1, exp1.cnt);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input logic r, input tmds_mode_t m, input logic [7:0] d,
                     input logic [1:0] c, input logic [3:0] a);
    @(negedge clk);
    rst = r; mode = m; din = d; ctrl = c; aux = a;
  endtask

  task automatic vid(input logic [7:0] d);
    cyc(1'b0, VIDEO, d, 2'b00, 4'h0);
  endtask

  // Checks lane 0 output of the symbol driven two cyc() calls earlier.
  task automatic lit(input string name, input logic [9:0] exp_dout, input int exp_disp);
    check({name, "_dout"}, dout0, exp_dout);
    check({name, "_disp"}, disp0, exp_disp);
  endtask

  logic [9:0] z_dout [10] = '{10'h100, 10'h3FF, 10'h100, 10'h3FF, 10'h100,
                              10'h3FF, 10'h100, 10'h3FF, 10'h100, 10'h100};
  int         z_disp [10] = '{-8, 2, -6, 4, -4, 6, -2, 8, 0, -8};
  logic [7:0] bytes  [12] = '{8'h10, 8'h5A, 8'hC3, 8'h01, 8'h7E, 8'h80,
                              8'hF0, 8'h0F, 8'h33, 8'hE7, 8'h55, 8'hFE};

  initial begin
    rst = 1'b1; mode = VIDEO; din = 8'h5A; ctrl = 2'b11; aux = 4'hF;
    cyc(1'b1, VIDEO, 8'h5A, 2'b11, 4'hF);
    lit("reset", 10'b1101010100, 0);
    check("reset_dout_ch1", dout1, 10'b1101010100);
    cyc(1'b1, VIDEO, 8'h5A, 2'b11, 4'hF);

    vid(8'hAA); lit("hold_1", 10'b1101010100, 0);
    vid(8'hAA); lit("hold_2", 10'b1101010100, 0);
    for (int i = 0; i < 4; i++) begin
      vid(8'hAA); lit("aa_balanced", 10'b1000110011, 0);
    end

    vid(8'h00); vid(8'h00);
    for (int k = 0; k < 10; k++) begin
      vid(8'h00); lit("zero_run", z_dout[k], z_disp[k]);
    end

    cyc(1'b0, CTRL, 8'h00, 2'b00, 4'h0);
    cyc(1'b0, CTRL, 8'h00, 2'b01, 4'h0);
    cyc(1'b0, CTRL, 8'h00, 2'b10, 4'h0); lit("ctrl_00", 10'b1101010100, 0);
    cyc(1'b0, CTRL, 8'h00, 2'b11, 4'h0); lit("ctrl_01", 10'b0010101011, 0);
    vid(8'hFF);                           lit("ctrl_10", 10'b0101010100, 0);
    vid(8'hFF);                           lit("ctrl_11", 10'b1010101011, 0);
    cyc(1'b0, TERC4, 8'h00, 2'b00, 4'h0); lit("video_ff_first", 10'h200, -8);
    cyc(1'b0, TERC4, 8'h00, 2'b00, 4'h8); lit("video_ff_second", 10'h0FF, -2);
    cyc(1'b0, TERC4, 8'h00, 2'b00, 4'hF); lit("terc4_0", 10'b1010011100, 0);
    cyc(1'b0, GUARD, 8'h00, 2'b00, 4'h0); lit("terc4_8", 10'b1011001100, 0);
    vid(8'h00);                           lit("terc4_f", 10'b1011000011, 0);
    vid(8'h00);                           lit("guard_ch0", 10'b1011001100, 0);
    check("guard_ch1", dout1, 10'b0100110011);
    vid(8'h00);                           lit("ilv_v1", 10'h100, -8);
    cyc(1'b0, GUARD, 8'h00, 2'b00, 4'h0); lit("ilv_v2", 10'h3FF, 2);
    vid(8'h00);                           lit("ilv_v3", 10'h100, -6);
    vid(8'h00);                           lit("ilv_guard", 10'b1011001100, 0);
    vid(8'h00);                           lit("ilv_after_guard", 10'h100, -8);
    vid(8'h00);                           lit("ilv_next", 10'h3FF, 2);

    cyc(1'b1, VIDEO, 8'h00, 2'b00, 4'h0);
    vid(8'hFF); lit("rst_mid_1", 10'b1101010100, 0);
    vid(8'hFF); lit("rst_mid_2", 10'b1101010100, 0);
    vid(8'hFF); lit("rst_resume", 10'h200, -8);

    for (int i = 0; i < 12; i++) vid(bytes[i]);
    cyc(1'b0, TERC4, 8'h00, 2'b00, 4'h5);
    for (int i = 0; i < 6; i++) vid(bytes[11 - i]);
    cyc(1'b0, CTRL, 8'h00, 2'b00, 4'h0);
    cyc(1'b0, CTRL, 8'h00, 2'b00, 4'h0);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
